// File: rtl/joybus_pkg.sv
// Shared Joybus definitions: transmitter states, bit timing and standard poll commands.
package joybus_pkg;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned CNT_W  = 7;

    localparam int unsigned CYC_SHORT     = 25;
    localparam int unsigned CYC_LONG      = 75;
    localparam int unsigned CYC_BIT       = 100;
    localparam int unsigned CYC_STOP_HIGH = 50;

    localparam logic [7:0]        N64_POLL = 8'h01;
    localparam logic [DATA_W-1:0] GC_POLL  = 24'h400302;

    typedef enum logic [2:0] {
        IDLE,
        BIT_LOW,
        BIT_HIGH,
        STOP_LOW,
        STOP_HIGH
    } jb_state_e;

    // Captured command: data shifts out MSB first, len counts remaining bits.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
    } jb_cmd_t;

    // Last phase-counter value of the low half of a bit.
    function automatic logic [CNT_W-1:0] low_last(input logic b);
        return b ? CNT_W'(CYC_SHORT - 1) : CNT_W'(CYC_LONG - 1);
    endfunction

    // Last phase-counter value of the released half of a bit.
    function automatic logic [CNT_W-1:0] high_last(input logic b);
        return b ? CNT_W'(CYC_LONG - 1) : CNT_W'(CYC_SHORT - 1);
    endfunction

endpackage

// File: rtl/joybus_tx.sv
// Joybus command transmitter: serialises up to 24 bits with pulse-width encoding,
// appends a stop bit and arms the downstream receiver as the line is released.
module joybus_tx
    import joybus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [LEN_W-1:0]  tx_len,
    output logic              JB_TX,
    output logic              tx_busy,
    output logic              rx_start,
    output logic              tx_done
);

    jb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    jb_cmd_t          cmd_q, cmd_d;
    logic             jb_tx_q, jb_tx_d;
    logic             busy_q, busy_d;
    logic             rx_start_q, rx_start_d;
    logic             done_q, done_d;
    logic             cur_bit;
    logic             len_ok;

    assign cur_bit = cmd_q.data[DATA_W-1];
    assign len_ok  = (tx_len != '0) && (tx_len <= LEN_W'(DATA_W));

    // State, counters and output flops; reset releases the line at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            jb_tx_q    <= 1'b1;
            busy_q     <= 1'b0;
            rx_start_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            jb_tx_q    <= jb_tx_d;
            busy_q     <= busy_d;
            rx_start_q <= rx_start_d;
            done_q     <= done_d;
        end
    end

    // Next state; outputs are derived from the next state so they land with it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        cmd_d      = cmd_q;
        jb_tx_d    = 1'b1;
        busy_d     = 1'b0;
        rx_start_d = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tx_start && len_ok) begin
                    state_d = BIT_LOW;
                    cmd_d   = '{data: tx_data, len: tx_len};
                end
            end
            BIT_LOW: begin
                if (cnt_q == low_last(cur_bit)) begin
                    state_d = BIT_HIGH;
                    cnt_d   = '0;
                end
            end
            BIT_HIGH: begin
                if (cnt_q == high_last(cur_bit)) begin
                    cnt_d      = '0;
                    cmd_d.data = {cmd_q.data[DATA_W-2:0], 1'b0};
                    cmd_d.len  = cmd_q.len - LEN_W'(1);
                    state_d    = (cmd_q.len == LEN_W'(1)) ? STOP_LOW : BIT_LOW;
                end
            end
            STOP_LOW: begin
                if (cnt_q == CNT_W'(CYC_SHORT - 1)) begin
                    state_d = STOP_HIGH;
                    cnt_d   = '0;
                end
            end
            STOP_HIGH: begin
                if (cnt_q == CNT_W'(CYC_STOP_HIGH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        jb_tx_d    = !((state_d == BIT_LOW) || (state_d == STOP_LOW));
        busy_d     = (state_d != IDLE);
        rx_start_d = (state_q == STOP_LOW) && (state_d == STOP_HIGH);
        done_d     = (state_d == STOP_HIGH) && (cnt_d == CNT_W'(CYC_STOP_HIGH - 1));
    end

    assign JB_TX    = jb_tx_q;
    assign tx_busy  = busy_q;
    assign rx_start = rx_start_q;
    assign tx_done  = done_q;

endmodule
